// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants and types for the time-setting clock block
package clock_pkg;

    localparam logic [1:0] BTN_IDLE  = 2'b11;
    localparam logic [1:0] BTN_SHORT = 2'b10;
    localparam logic [1:0] BTN_LONG  = 2'b01;
    localparam logic [1:0] BTN_HELD  = 2'b00;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_EDIT_HR  = 2'b01,
        ST_EDIT_MIN = 2'b10
    } edit_state_t;

    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo MAX+1 up/down counter with clear and wrap carry
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_clr,
    output logic [W-1:0] o_value,
    output logic         o_carry
);

    logic [W-1:0] r_value;

    // Carry is combinational so a whole carry chain settles in one cycle.
    assign o_carry = i_inc && (r_value == W'(MAX));
    assign o_value = r_value;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= (r_value == W'(MAX)) ? '0 : r_value + 1'b1;
        end else if (i_dec) begin
            r_value <= (r_value == '0) ? W'(MAX) : r_value - 1'b1;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - clock time keeping and button-driven setting; TIME_SET_TIMEOUT_EN enables edit timeout
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int REP_CNT   = 25_000_000,
    parameter int TIMEOUT_S = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sec_tick,
    input  logic [1:0] i_mode_btn,
    input  logic [1:0] i_inc_btn,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic [1:0] o_edit,
    output logic       o_blink
);

    edit_state_t r_state;
    edit_state_t w_next_state;
    logic        r_blink;
    logic [31:0] r_rep_cnt;

    logic w_mode_short, w_mode_long, w_mode_evt;
    logic w_inc_short, w_inc_long, w_inc_held;
    logic w_in_edit, w_edit_ok, w_rep_step, w_up, w_down;
    logic w_sec_carry, w_min_carry, w_unused_day_wrap;
    logic w_timeout, w_leave_edit;

    assign w_mode_short = (i_mode_btn == BTN_SHORT);
    assign w_mode_long  = (i_mode_btn == BTN_LONG);
    assign w_mode_evt   = w_mode_short || w_mode_long;
    assign w_inc_short  = (i_inc_btn == BTN_SHORT);
    assign w_inc_long   = (i_inc_btn == BTN_LONG);
    assign w_inc_held   = (i_inc_btn == BTN_HELD);

    // A mode event in the same cycle suppresses any field change.
    assign w_in_edit  = (r_state != ST_RUN);
    assign w_edit_ok  = w_in_edit && !w_mode_evt;
    assign w_rep_step = w_in_edit && w_inc_held && (r_rep_cnt == '0);
    assign w_up       = w_edit_ok && (w_inc_short || w_rep_step);
    assign w_down     = w_edit_ok && w_inc_long;

`ifdef TIME_SET_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        w_activity;

    assign w_activity = w_mode_evt || w_inc_short || w_inc_long || w_inc_held;
    assign w_timeout  = w_in_edit && i_sec_tick && !w_activity &&
                        (r_to_cnt == 32'(TIMEOUT_S - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_in_edit || w_activity || w_timeout) begin
            r_to_cnt <= '0;
        end else if (i_sec_tick) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_s = TIMEOUT_S;
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:      if (w_mode_long) w_next_state = ST_EDIT_HR;
            ST_EDIT_HR:  if (w_mode_long) w_next_state = ST_RUN;
                         else if (w_mode_short) w_next_state = ST_EDIT_MIN;
            ST_EDIT_MIN: if (w_mode_long) w_next_state = ST_RUN;
                         else if (w_mode_short) w_next_state = ST_EDIT_HR;
            default:     w_next_state = ST_RUN;
        endcase
        if (w_timeout) w_next_state = ST_RUN;
    end

    assign w_leave_edit = w_in_edit && (w_next_state == ST_RUN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_RUN;
            r_blink   <= 1'b1;
            r_rep_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_RUN || w_next_state == ST_RUN)
                r_blink <= 1'b1;
            else if (w_up || w_down)
                r_blink <= 1'b1;
            else if (i_sec_tick)
                r_blink <= ~r_blink;
            if (!w_inc_held || !w_in_edit || r_rep_cnt == 32'(REP_CNT - 1))
                r_rep_cnt <= '0;
            else
                r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    mod_counter #(.MAX(SEC_MAX), .W(6)) u_sec (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (r_state == ST_RUN && i_sec_tick),
        .i_dec   (1'b0),
        .i_clr   (w_leave_edit),
        .o_value (o_seconds),
        .o_carry (w_sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX), .W(6)) u_min (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   ((r_state == ST_RUN && w_sec_carry) || (r_state == ST_EDIT_MIN && w_up)),
        .i_dec   (r_state == ST_EDIT_MIN && w_down),
        .i_clr   (1'b0),
        .o_value (o_minutes),
        .o_carry (w_min_carry)
    );

    mod_counter #(.MAX(HR_MAX), .W(5)) u_hr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   ((r_state == ST_RUN && w_min_carry) || (r_state == ST_EDIT_HR && w_up)),
        .i_dec   (r_state == ST_EDIT_HR && w_down),
        .i_clr   (1'b0),
        .o_value (o_hours),
        .o_carry (w_unused_day_wrap)
    );

    assign o_edit  = r_state;
    assign o_blink = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl with a time-of-day reference model
module tb_time_set_ctrl;

    localparam int REP = 4;
    localparam int TMO = 3;
    localparam logic [1:0] I = 2'b11, S = 2'b10, L = 2'b01, H = 2'b00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sec_tick = 1'b0;
    logic [1:0] mode_btn = I;
    logic [1:0] inc_btn = I;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [1:0] edit;
    logic       blink;

    typedef struct {
        int h;
        int m;
        int s;
        int st;
        int b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_h, m_m, m_s, m_st, m_blink, m_held, m_idle;

    time_set_ctrl #(.REP_CNT(REP), .TIMEOUT_S(TMO)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sec_tick (sec_tick),
        .i_mode_btn (mode_btn),
        .i_inc_btn  (inc_btn),
        .o_hours    (hours),
        .o_minutes  (minutes),
        .o_seconds  (seconds),
        .o_edit     (edit),
        .o_blink    (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_blink = 1; m_held = 0; m_idle = 0;
    endtask

    // Time of day is advanced as seconds-since-midnight; edits act on one field only.
    task automatic model_update(input int mode, input int inc, input bit tick);
        bit ms, ml, is, il, ih, ed, step_up;
        int nst, d, tot;
        ms = (mode == 2); ml = (mode == 1);
        is = (inc == 2);  il = (inc == 1); ih = (inc == 0);
        ed = (m_st != 0);
        step_up = ed && ih && (m_held % REP == 0);
        m_held = (ed && ih) ? m_held + 1 : 0;
        nst = m_st;
        if (!ed) begin
            if (ml) nst = 1;
        end else if (ml) nst = 0;
        else if (ms) nst = 3 - m_st;
`ifdef TIME_SET_TIMEOUT_EN
        if (!ed || ms || ml || is || il || ih) m_idle = 0;
        else if (tick) begin
            m_idle++;
            if (m_idle >= TMO) begin
                nst = 0;
                m_idle = 0;
            end
        end
`endif
        d = 0;
        if (ed && !ms && !ml) d = (is || step_up) ? 1 : (il ? -1 : 0);
        if (m_st == 1) m_h = (m_h + d + 24) % 24;
        else if (m_st == 2) m_m = (m_m + d + 60) % 60;
        if (!ed && tick) begin
            tot = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = tot / 3600;
            m_m = (tot / 60) % 60;
            m_s = tot % 60;
        end
        if (ed && nst == 0) m_s = 0;
        if (!ed || nst == 0) m_blink = 1;
        else if (d != 0) m_blink = 1;
        else if (tick) m_blink = 1 - m_blink;
        m_st = nst;
    endtask

    task automatic step(input logic [1:0] mode, input logic [1:0] inc, input logic tick);
        exp_t e;
        @(negedge clk);
        mode_btn = mode;
        inc_btn  = inc;
        sec_tick = tick;
        model_update(int'(mode), int'(inc), tick);
        e.h = m_h; e.m = m_m; e.s = m_s; e.st = m_st; e.b = m_blink;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hours", int'(hours), e.h);
                chk("minutes", int'(minutes), e.m);
                chk("seconds", int'(seconds), e.s);
                chk("edit", int'(edit), e.st);
                chk("blink", int'(blink), e.b);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hours"}, int'(hours), 0);
        chk({tag, "_minutes"}, int'(minutes), 0);
        chk({tag, "_seconds"}, int'(seconds), 0);
        chk({tag, "_edit"}, int'(edit), 0);
        chk({tag, "_blink"}, int'(blink), 1);
    endtask

    initial begin : stimulus
        logic [1:0] rm, ri;
        int r;
        model_reset();
        #2 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Set 23:59 through edit mode using decrement wrap, then run up to midnight.
        step(L, I, 0);
        step(I, L, 0);
        step(S, I, 0);
        step(I, L, 0);
        step(S, I, 0);
        step(L, I, 0);
        repeat (59) step(I, I, 1);
        settle();
        chk("pre_wrap_hours", int'(hours), 23);
        chk("pre_wrap_seconds", int'(seconds), 59);
        step(I, I, 1);
        settle();
        chk("wrap_hours", int'(hours), 0);
        chk("wrap_minutes", int'(minutes), 0);
        chk("wrap_seconds", int'(seconds), 0);

        // Auto-repeat from 22: steps at held cycles 0, 4 and 8.
        step(L, I, 0);
        step(I, L, 0);
        step(I, L, 0);
        repeat (9) step(I, H, 0);
        step(I, I, 0);
        settle();
        chk("repeat_hours", int'(hours), 1);

        // Mode wins over a simultaneous inc.
        step(S, S, 0);
        settle();
        chk("collide_edit", int'(edit), 2);
        chk("collide_hours", int'(hours), 1);

        // Entering edit on a tick cycle still counts that second.
        step(L, I, 0);
        step(L, I, 1);
        settle();
        chk("enter_tick_seconds", int'(seconds), 1);
        chk("enter_tick_edit", int'(edit), 1);

        repeat (TMO) step(I, I, 1);
        settle();
`ifdef TIME_SET_TIMEOUT_EN
        chk("timeout_edit", int'(edit), 0);
        chk("timeout_seconds", int'(seconds), 0);
`else
        chk("no_timeout_edit", int'(edit), 1);
`endif

        // Asynchronous reset in the middle of an auto-repeat.
        if (m_st == 0) step(L, I, 0);
        repeat (6) step(I, H, 0);
        settle();
        mode_btn = I;
        inc_btn  = I;
        sec_tick = 1'b0;
        rst_n    = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int n = 0; n < 3000; n++) begin
            r  = int'($urandom_range(0, 99));
            rm = (r < 4) ? L : (r < 10) ? S : (r < 12) ? H : I;
            r  = int'($urandom_range(0, 99));
            ri = (r < 10) ? S : (r < 20) ? L : (r < 35) ? H : I;
            step(rm, ri, ($urandom_range(0, 3) == 0));
        end
        step(I, I, 0);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
